paramtype_deser: RTL and testbench



---
 rtl/paramtype_deser.sv | 86 ++++++++
 tb/tb_paramtype_deser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/paramtype_deser.sv
// paramtype_deser: rebuilds one T-typed word from LSB-first S-bit beats and offers it on a valid/ready port
module paramtype_deser #(
    parameter int S = 1,
    parameter type T = logic [7:0],
    localparam int W = $bits(T),
    localparam int N = (W + S - 1) / S,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic [S-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output T              out_data,
    input  logic          out_ready,
    output logic          sync_err,
    output logic [CW-1:0] beat_cnt
);
    localparam int SW = N * S;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0] r_cnt, w_idx;
    logic [W-1:0]  w_word;
    T              r_data;
    logic          r_sync;
    logic          w_accept, w_resync, w_last;

    assign w_accept = in_valid && (r_state == COLLECT);
    assign w_resync = w_accept && in_first && (r_cnt != '0);
    assign w_idx    = w_resync ? '0 : r_cnt;
    assign w_last   = w_accept && (w_idx == CW'(N - 1));

    // Merge the incoming beat into its slot; a resync starts again from an empty word
    always_comb begin
        w_shift_nxt = w_resync ? '0 : r_shift;
        for (int k = 0; k < N; k++)
            if (w_idx == CW'(k)) w_shift_nxt[k*S +: S] = in_data;
    end

    if (SW > W) begin : g_trim
        assign w_word = w_shift_nxt[W-1:0];
    end else begin : g_exact
        assign w_word = w_shift_nxt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake outputs: gather beats, then hold the word until taken
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == COLLECT);
        out_valid   = (r_state == HOLD);
        w_state_nxt = (r_state == COLLECT) ? (w_last ? HOLD : COLLECT)
                                           : (out_ready ? COLLECT : HOLD);
    end

    // Datapath: shift register, beat counter, output word and resync pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_sync  <= 1'b0;
        end else begin
            r_sync <= w_resync;
            if (w_accept) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= w_last ? '0 : w_idx + CW'(1);
            end
            if (w_last) r_data <= T'(w_word);
        end
    end

    assign out_data = r_data;
    assign sync_err = r_sync;
    assign beat_cnt = r_cnt;
endmodule

// File: tb/tb_paramtype_deser.sv
// tb_paramtype_deser: scoreboard bench driving six differently parameterised deserializers one at a time
module tb_paramtype_deser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, out_ready;
    logic [7:0]  in_data;
    logic [2:0]  sel;
    logic [5:0]  ov, ir, se;
    logic [11:0] od [6];
    logic [3:0]  bc [6];
    logic [7:0]  od0, od1;
    logic [11:0] od2;
    logic [5:0]  od3;
    logic [3:0]  od4, bc0;
    logic [4:0]  od5;
    logic [1:0]  bc1, bc2, bc3;
    logic [2:0]  bc4;
    logic        bc5;
    logic [15:0] sb_q [$];
    logic [15:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    paramtype_deser #(.S(1), .T(logic [7:0])) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd0), .in_first(in_first),
        .in_data(in_data[0:0]), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0),
        .out_ready(out_ready), .sync_err(se[0]), .beat_cnt(bc0));
    paramtype_deser #(.S(3), .T(logic [7:0])) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd1), .in_first(in_first),
        .in_data(in_data[2:0]), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1),
        .out_ready(out_ready), .sync_err(se[1]), .beat_cnt(bc1));
    paramtype_deser #(.S(4), .T(logic [11:0])) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd2), .in_first(in_first),
        .in_data(in_data[3:0]), .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2),
        .out_ready(out_ready), .sync_err(se[2]), .beat_cnt(bc2));
    paramtype_deser #(.S(2), .T(logic [5:0])) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd3), .in_first(in_first),
        .in_data(in_data[1:0]), .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od3),
        .out_ready(out_ready), .sync_err(se[3]), .beat_cnt(bc3));
    paramtype_deser #(.S(1), .T(logic [3:0])) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd4), .in_first(in_first),
        .in_data(in_data[0:0]), .in_ready(ir[4]), .out_valid(ov[4]), .out_data(od4),
        .out_ready(out_ready), .sync_err(se[4]), .beat_cnt(bc4));
    paramtype_deser #(.S(8), .T(logic [4:0])) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3'd5), .in_first(in_first),
        .in_data(in_data), .in_ready(ir[5]), .out_valid(ov[5]), .out_data(od5),
        .out_ready(out_ready), .sync_err(se[5]), .beat_cnt(bc5));

    assign od[0] = {4'b0, od0};
    assign od[1] = {4'b0, od1};
    assign od[2] = od2;
    assign od[3] = {6'b0, od3};
    assign od[4] = {8'b0, od4};
    assign od[5] = {7'b0, od5};
    assign bc[0] = bc0;
    assign bc[1] = {2'b0, bc1};
    assign bc[2] = {2'b0, bc2};
    assign bc[3] = {2'b0, bc3};
    assign bc[4] = {1'b0, bc4};
    assign bc[5] = {3'b0, bc5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected word on every output handshake
    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (rst_n && ov[k] && out_ready) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_inst", 32'(k), 32'(mon_e[15:12]));
                    chk("sb_data", 32'(od[k]), 32'(mon_e[11:0]));
                end
            end
        end
    end

    task automatic idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic f);
        int n = 0;
        in_valid = 1'b1;
        in_first = f;
        in_data  = d;
        while (!ir[sel] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ir[sel]) chk("beat_timeout", 32'(ir[sel]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_data  = 'x;
    endtask

    task automatic frame(input int k, input int s, input int w, input logic [7:0] b [8],
                         input logic [7:0] f, input int n);
        int          nb = (w + s - 1) / s;
        int          idx = 0;
        logic [31:0] word = 0;
        logic        rs;
        sel = 3'(k);
        for (int i = 0; i < n; i++) begin
            rs = f[i] && idx != 0;
            if (rs) begin
                word = 0;
                idx  = 0;
            end
            word = word | (32'(b[i]) << (idx * s));
            idx++;
            if (idx == nb) begin
                sb_q.push_back({4'(k), 12'(word & ((32'd1 << w) - 1))});
                word = 0;
                idx  = 0;
            end
            beat(b[i], f[i]);
            chk("beat_cnt", 32'(bc[k]), 32'(idx));
            chk("sync_err", 32'(se[k]), 32'(rs));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1; sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rst_ov", 32'(ov[k]), 32'd0);
            chk("rst_ir", 32'(ir[k]), 32'd1);
            chk("rst_se", 32'(se[k]), 32'd0);
            chk("rst_bc", 32'(bc[k]), 32'd0);
            chk("rst_od", 32'(od[k]), 32'd0);
        end
        frame(0, 1, 8, '{1, 0, 1, 1, 0, 0, 0, 0}, 8'h01, 8);
        chk("t1_latency", 32'(ov[0]), 32'd1);
        chk("t1_word", 32'(od[0]), 32'h0D);
        idle();
        frame(1, 3, 8, '{5, 6, 7, 0, 0, 0, 0, 0}, 8'h01, 3);
        chk("t2_word", 32'(od[1]), 32'hF5);
        idle();
        out_ready = 1'b0;
        frame(2, 4, 12, '{4'hA, 4'hB, 4'hC, 0, 0, 0, 0, 0}, 8'h01, 3);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_ov", 32'(ov[2]), 32'd1);
            chk("t3_hold_od", 32'(od[2]), 32'hCBA);
            chk("t3_hold_ir", 32'(ir[2]), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_data = 8'h1;
        @(posedge clk);
        #1;
        chk("t3_release_ir", 32'(ir[2]), 32'd1);
        chk("t3_release_ov", 32'(ov[2]), 32'd0);
        chk("t3_no_accept", 32'(bc[2]), 32'd0);
        in_valid = 1'b0; in_first = 1'b0; in_data = 'x;
        idle();
        frame(3, 2, 6, '{3, 1, 2, 0, 1, 0, 0, 0}, 8'h04, 5);
        chk("t4_word", 32'(od[3]), 32'h12);
        idle();
        sel = 3'd4;
        beat(8'h1, 1'b1);
        beat(8'h1, 1'b0);
        chk("t5_partial", 32'(bc[4]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_bc", 32'(bc[4]), 32'd0);
        chk("t5_async_ov", 32'(ov[4]), 32'd0);
        chk("t5_async_se", 32'(se[4]), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_post_se", 32'(se[4]), 32'd0);
        chk("t5_post_ir", 32'(ir[4]), 32'd1);
        frame(4, 1, 4, '{1, 1, 1, 1, 0, 0, 0, 0}, 8'h01, 4);
        chk("t5_word", 32'(od[4]), 32'hF);
        idle();
        sel = 3'd5;
        repeat (3) sb_q.push_back({4'd5, 12'h01F});
        in_valid = 1'b1; in_first = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("t6_ov_alt", 32'(ov[5]), 32'(i % 2 == 0));
            chk("t6_ir_alt", 32'(ir[5]), 32'(i % 2));
        end
        in_valid = 1'b0; in_first = 1'b0; in_data = 'x;
        frame(5, 8, 5, '{8'hEA, 0, 0, 0, 0, 0, 0, 0}, 8'h01, 1);
        chk("t6_trunc", 32'(od[5]), 32'h0A);
        idle();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
